// File: rtl/decode_stage.sv
// Decode stage: splits an instruction into fields, reads operands
// and hands a registered bundle to execute.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   in_valid/in_ready   fetch-side handshake
//   in_instr, in_pc     instruction word and its address
//   rs1_addr, rs2_addr  register-file read addresses (combinational)
//   rs1_data, rs2_data  register-file read data
//   wb_write_*          same-cycle write-back port, used for bypass
//   flush               kill the stage contents
//   out_valid/out_ready execute-side handshake
//   out_*               registered decoded bundle
module decode_stage #(
    parameter int XLEN      = 32,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_write_enable,
    input  logic [4:0]      wb_write_address,
    input  logic [XLEN-1:0] wb_write_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1_addr,
    output logic [4:0]      out_rs2_addr,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            out_funct7_5,
    output logic            out_reg_write,
    output logic            out_is_load
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic            is_i;
    logic            is_s;
    logic            is_b;
    logic            is_u;
    logic            is_j;
    logic [XLEN-1:0] imm;
    logic            reg_write;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            byp1;
    logic            byp2;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            hazard;
    logic            fire;

    assign opcode   = in_instr[6:0];
    assign rd       = in_instr[11:7];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    assign is_i = (opcode == OP_LOAD) || (opcode == OP_IMM)
               || (opcode == OP_JALR);
    assign is_s = (opcode == OP_STORE);
    assign is_b = (opcode == OP_BRANCH);
    assign is_u = (opcode == OP_LUI) || (opcode == OP_AUIPC);
    assign is_j = (opcode == OP_JAL);

    always_comb begin
        imm = '0;
        unique case (1'b1)
            is_i: imm = {{20{in_instr[31]}}, in_instr[31:20]};
            is_s: imm = {{20{in_instr[31]}}, in_instr[31:25],
                         in_instr[11:7]};
            is_b: imm = {{20{in_instr[31]}}, in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
            is_u: imm = {in_instr[31:12], 12'b0};
            is_j: imm = {{12{in_instr[31]}}, in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign reg_write = (rd != 5'd0) &&
        (is_i || is_u || is_j || (opcode == OP_REG));

    assign uses_rs1 = !(is_u || is_j);
    assign uses_rs2 = (opcode == OP_REG) || is_s || is_b;

    assign byp1 = WB_BYPASS && wb_write_enable
               && (wb_write_address != 5'd0)
               && (wb_write_address == rs1_addr);
    assign byp2 = WB_BYPASS && wb_write_enable
               && (wb_write_address != 5'd0)
               && (wb_write_address == rs2_addr);

    // x0 wins over any bypass
    assign op1 = (rs1_addr == 5'd0) ? '0
               : byp1 ? wb_write_data : rs1_data;
    assign op2 = (rs2_addr == 5'd0) ? '0
               : byp2 ? wb_write_data : rs2_data;

    // load-use: the loaded value is not available until after execute
    assign hazard = out_valid && out_is_load && (out_rd != 5'd0)
        && in_valid
        && ((uses_rs1 && (rs1_addr == out_rd))
         || (uses_rs2 && (rs2_addr == out_rd)));

    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign fire     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_rs1_data  <= '0;
            out_rs2_data  <= '0;
            out_imm       <= '0;
            out_rd        <= '0;
            out_rs1_addr  <= '0;
            out_rs2_addr  <= '0;
            out_opcode    <= '0;
            out_funct3    <= '0;
            out_funct7_5  <= 1'b0;
            out_reg_write <= 1'b0;
            out_is_load   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (fire) begin
            out_valid     <= 1'b1;
            out_pc        <= in_pc;
            out_rs1_data  <= op1;
            out_rs2_data  <= op2;
            out_imm       <= imm;
            out_rd        <= rd;
            out_rs1_addr  <= rs1_addr;
            out_rs2_addr  <= rs2_addr;
            out_opcode    <= opcode;
            out_funct3    <= in_instr[14:12];
            out_funct7_5  <= in_instr[30];
            out_reg_write <= reg_write;
            out_is_load   <= (opcode == OP_LOAD);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: scoreboard of expected bundles plus
// directed checks for hazard, backpressure, flush and reset.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_write_enable;
    logic [4:0]  wb_write_address;
    logic [31:0] wb_write_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;
    logic [31:0] out_imm;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1_addr;
    logic [4:0]  out_rs2_addr;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7_5;
    logic        out_reg_write;
    logic        out_is_load;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_instr         (in_instr),
        .in_pc            (in_pc),
        .rs1_addr         (rs1_addr),
        .rs2_addr         (rs2_addr),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .wb_write_enable  (wb_write_enable),
        .wb_write_address (wb_write_address),
        .wb_write_data    (wb_write_data),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_rs1_data     (out_rs1_data),
        .out_rs2_data     (out_rs2_data),
        .out_imm          (out_imm),
        .out_rd           (out_rd),
        .out_rs1_addr     (out_rs1_addr),
        .out_rs2_addr     (out_rs2_addr),
        .out_opcode       (out_opcode),
        .out_funct3       (out_funct3),
        .out_funct7_5     (out_funct7_5),
        .out_reg_write    (out_reg_write),
        .out_is_load      (out_is_load)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f75;
        logic        rw;
        logic        ld;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(
        input logic [31:0] ins, input logic [31:0] pc,
        input logic [31:0] r1d, input logic [31:0] r2d,
        input logic we, input logic [4:0] wa,
        input logic [31:0] wd);
        exp_t e;
        logic [6:0] op;
        op    = ins[6:0];
        e.pc  = pc;
        e.op  = op;
        e.rd  = ins[11:7];
        e.a1  = ins[19:15];
        e.a2  = ins[24:20];
        e.f3  = ins[14:12];
        e.f75 = ins[30];
        if (e.a1 == 0) e.r1 = 0;
        else if (we && wa == e.a1) e.r1 = wd;
        else e.r1 = r1d;
        if (e.a2 == 0) e.r2 = 0;
        else if (we && wa == e.a2) e.r2 = wd;
        else e.r2 = r2d;
        case (op)
            7'h03, 7'h13, 7'h67:
                e.imm = {{20{ins[31]}}, ins[31:20]};
            7'h23:
                e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            7'h63:
                e.imm = {{19{ins[31]}}, ins[31], ins[7],
                         ins[30:25], ins[11:8], 1'b0};
            7'h37, 7'h17:
                e.imm = {ins[31:12], 12'h000};
            7'h6f:
                e.imm = {{11{ins[31]}}, ins[31], ins[19:12],
                         ins[20], ins[30:21], 1'b0};
            default: e.imm = 0;
        endcase
        e.rw = (e.rd != 0) && (op inside {7'h33, 7'h13, 7'h03,
                    7'h37, 7'h17, 7'h6f, 7'h67});
        e.ld = (op == 7'h03);
        return e;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1d, input logic [31:0] r2d);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        rs1_data = r1d;
        rs2_data = r2d;
    endtask

    // One cycle: called just after a negedge with inputs set.
    task automatic step();
        logic fire_in;
        logic fire_out;
        exp_t e;
        #1;
        fire_in  = in_valid && in_ready;
        fire_out = out_valid && out_ready;
        if (fire_out === 1'b1) begin
            chk("sb_nonempty", sb.size(), (sb.size() == 0) ? 1 : sb.size());
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pc", out_pc, e.pc);
                chk("rs1_data", out_rs1_data, e.r1);
                chk("rs2_data", out_rs2_data, e.r2);
                chk("imm", out_imm, e.imm);
                chk("rd", {27'd0, out_rd}, {27'd0, e.rd});
                chk("rs1_addr", {27'd0, out_rs1_addr}, {27'd0, e.a1});
                chk("rs2_addr", {27'd0, out_rs2_addr}, {27'd0, e.a2});
                chk("opcode", {25'd0, out_opcode}, {25'd0, e.op});
                chk("funct3", {29'd0, out_funct3}, {29'd0, e.f3});
                chk("funct7_5", {31'd0, out_funct7_5}, {31'd0, e.f75});
                chk("reg_write", {31'd0, out_reg_write}, {31'd0, e.rw});
                chk("is_load", {31'd0, out_is_load}, {31'd0, e.ld});
            end
        end
        if (!reset || flush) sb.delete();
        if (fire_in === 1'b1 && reset)
            sb.push_back(model(in_instr, in_pc, rs1_data, rs2_data,
                wb_write_enable, wb_write_address, wb_write_data));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset            = 1'b0;
        in_valid         = 1'b0;
        in_instr         = '0;
        in_pc            = '0;
        rs1_data         = '0;
        rs2_data         = '0;
        wb_write_enable  = 1'b0;
        wb_write_address = '0;
        wb_write_data    = '0;
        flush            = 1'b0;
        out_ready        = 1'b1;
        @(negedge clk);
        step();
        step();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_rd", {27'd0, out_rd}, 32'd0);
        reset = 1'b1;

        // addi x5,x1,-3
        drive(32'hFFD08293, 32'h100, 32'h10, 32'h0);
        step();
        chk("addi_valid", {31'd0, out_valid}, 32'd1);
        chk("addi_rs1", out_rs1_data, 32'h10);
        chk("addi_imm", out_imm, 32'hFFFFFFFD);
        chk("addi_rd", {27'd0, out_rd}, 32'd5);
        chk("addi_rw", {31'd0, out_reg_write}, 32'd1);

        // add x3,x1,x2 with write-back bypass on x2
        wb_write_enable  = 1'b1;
        wb_write_address = 5'd2;
        wb_write_data    = 32'hABCD;
        drive(32'h002081B3, 32'h104, 32'h11, 32'h0);
        step();
        chk("byp_rs2", out_rs2_data, 32'hABCD);
        chk("byp_rs1_none", out_rs1_data, 32'h11);
        wb_write_address = 5'd0;
        drive(32'h002081B3, 32'h108, 32'h11, 32'h0);
        step();
        chk("byp_x0", out_rs2_data, 32'h0);
        wb_write_address = 5'd1;
        wb_write_data    = 32'h77;
        drive(32'h002081B3, 32'h10C, 32'h11, 32'h22);
        step();
        chk("byp_rs1", out_rs1_data, 32'h77);
        wb_write_enable = 1'b0;

        // addi x5,x0,5: x0 source reads zero
        drive(32'h00500293, 32'h110, 32'h55, 32'h0);
        step();
        chk("x0_rs1", out_rs1_data, 32'h0);

        // lw x6,0(x1) then add x7,x6,x6
        drive(32'h0000A303, 32'h114, 32'h200, 32'h0);
        step();
        drive(32'h006303B3, 32'h118, 32'h33, 32'h44);
        #1;
        chk("hz_ready", {31'd0, in_ready}, 32'd0);
        step();
        #1;
        chk("hz_bubble", {31'd0, out_valid}, 32'd0);
        chk("hz_ready2", {31'd0, in_ready}, 32'd1);
        step();
        chk("hz_add_rd", {27'd0, out_rd}, 32'd7);

        // sw x2,-4(x1) then backpressure for 3 cycles
        drive(32'hFE20AE23, 32'h200, 32'h1, 32'h2);
        step();
        out_ready = 1'b0;
        drive(32'hFE208CE3, 32'h204, 32'h3, 32'h4);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_imm", out_imm, 32'hFFFFFFFC);
            chk("bp_pc", out_pc, 32'h200);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release", {31'd0, in_ready}, 32'd1);
        step();
        chk("beq_imm", out_imm, 32'hFFFFFFF8);
        drive(32'hFFFFF2B7, 32'h208, 32'h0, 32'h0);
        step();
        chk("lui_imm", out_imm, 32'hFFFFF000);
        drive(32'hFF1FF0EF, 32'h20C, 32'h0, 32'h0);
        step();
        chk("jal_imm", out_imm, 32'hFFFFFFF0);
        chk("jal_rw", {31'd0, out_reg_write}, 32'd1);

        // flush while full
        out_ready = 1'b0;
        flush     = 1'b1;
        drive(32'h00500293, 32'h300, 32'h0, 32'h0);
        #1;
        chk("fl_ready", {31'd0, in_ready}, 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;

        // reset during a transfer
        drive(32'hFFD08293, 32'h400, 32'h10, 32'h0);
        reset = 1'b0;
        step();
        chk("rt_valid", {31'd0, out_valid}, 32'd0);
        chk("rt_imm", out_imm, 32'h0);
        reset = 1'b1;

        drive(32'h002081B3, 32'h500, 32'h5, 32'h6);
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 SHALL have parameter: WB_BYPASS, 1, 1 enables write-back to decode bypass, 0 disables it.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port: reset  in  1  synchronous, active-low reset; sampled only on posedge clk.
REQ-005 SHALL have ports: in_valid in 1, in_ready out 1, in_instr in 32, in_pc in 32  fetch-side handshake and payload.
REQ-006 SHALL have ports: rs1_addr out 5, rs2_addr out 5, rs1_data in 32, rs2_data in 32  combinational register-file read ports (x0 reads 0).
REQ-007 SHALL have ports: wb_write_enable in 1, wb_write_address in 5, wb_write_data in 32  same-cycle register-file write, used for bypass.
REQ-008 SHALL have port: flush  in  1  kill the contents of the stage (taken branch or jump).
REQ-009 SHALL have ports: out_valid out 1, out_ready in 1  execute-side handshake.
REQ-010 SHALL have registered outputs: out_pc 32, out_rs1_data 32, out_rs2_data 32, out_imm 32, out_rd 5, out_rs1_addr 5, out_rs2_addr 5, out_opcode 7, out_funct3 3, out_funct7_5 1, out_reg_write 1, out_is_load 1.

Function
REQ-011 SHALL drive rs1_addr = in_instr[19:15] and rs2_addr = in_instr[24:20] combinationally, regardless of in_valid.
REQ-012 SHALL apply a bypass when WB_BYPASS=1, wb_write_enable=1, wb_write_address!=0, and wb_write_address equals rs1_addr (or rs2_addr): the captured operand is wb_write_data instead of rs*_data.
REQ-013 SHALL force a captured operand to 0 when its source address is 0, overriding any bypass.
REQ-014 SHALL generate out_imm sign-extended by opcode:
  - I-type (0000011, 0010011, 1100111): instr[31:20].
  - S-type (0100011): {instr[31:25], instr[11:7]}.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All other opcodes: 0.
REQ-015 SHALL set out_reg_write=1 for opcodes 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111 when rd!=0, else 0; out_is_load=1 only for opcode 0000011.
REQ-016 SHALL define uses_rs1 as true for all opcodes except 0110111, 0010111, 1101111; uses_rs2 as true only for 0110011, 0100011, 1100011.
REQ-017 SHALL assert hazard when all of the following hold: out_valid=1, out_is_load=1, out_rd!=0, in_valid=1, and (uses_rs1 and rs1_addr==out_rd, or uses_rs2 and rs2_addr==out_rd).
REQ-018 SHALL compute in_ready = !flush and !hazard and (!out_valid or out_ready), combinationally.
REQ-019 SHALL, on a posedge with in_valid and in_ready both 1, load every out_* field from the current instruction and set out_valid=1 (one-cycle latency).
REQ-020 SHALL, on a posedge with out_valid=1, out_ready=1, and no transfer in, clear out_valid; this inserts a bubble during hazard.
REQ-021 SHALL hold all out_* fields stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on a posedge with flush=1, clear out_valid; flush has priority over transfer and hold.
REQ-023 SHALL keep payload registers unchanged when out_valid is cleared; only out_valid is qualified.

Reset
REQ-024 SHALL, on a posedge with reset=0, clear out_valid and every out_* register to 0, with priority over flush and transfer.
REQ-025 SHALL hold in_ready=0 is not required during reset; any transfer accepted while reset=0 is discarded.

Verification
REQ-026 SHALL cover, after reset: addi x5,x1,-3 (0xFFD08293), rs1_data=0x10 -> next cycle out_valid=1, out_rs1_data=0x10, out_imm=0xFFFFFFFD, out_rd=5, out_reg_write=1.
REQ-027 SHALL cover bypass: add x3,x1,x2 with wb_write_enable=1, wb_write_address=2, wb_write_data=0xABCD, rs2_data=0x0 -> out_rs2_data=0xABCD; the same stimulus with wb_write_address=0 -> out_rs2_data=0x0.
REQ-028 SHALL cover load-use: lw x6,0(x1) accepted, then add x7,x6,x6 presented with out_ready=1 -> in_ready=0 for one cycle, out_valid=0 (bubble) for one cycle, then the add is accepted.
REQ-029 SHALL cover backpressure: out_ready=0 for 3 cycles with the stage full -> in_ready=0 and out_* constant; after out_ready=1 the next instruction is accepted.
REQ-030 SHALL cover flush and reset: flush=1 while full -> out_valid=0 next cycle; reset=0 during a transfer -> out_valid=0 and out_imm=0 next cycle.
REQ-031 SHALL cover immediates: sw, beq, lui, and jal encodings with negative immediates -> out_imm matches the REQ-014 sign extension.
